aposta_tx: RTL
==============

# aposta_tx

Bet transmitter for the lottery checker. Latches a complete bet of `NDIGITS` BCD digits on a start handshake, then sends it to the checker as a timed sequence of `insere` strobes, one digit per strobe, followed by one `fim_jogo` strobe. It sits between the bet-entry front end (keypad/testbench) and the checker's `numero`/`insere`/`fim_jogo` inputs. It also rejects malformed bets and counts completed games.

## Interface
Parameters:
- `NDIGITS`, default 5: digits per bet. Must be ≥ 2.
- `GAP`, default 1: idle cycles between consecutive strobes. Range 0..15.

Ports:
- `clock` in 1: system clock. All state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: request to send `aposta`. Sampled only while `ready`=1.
- `cancela` in 1: synchronous abort of a transmission in progress.
- `aposta` in 4*NDIGITS: bet digits. Most-significant nibble is sent first.
- `ready` out 1: block idle, `start` will be accepted. Equals `!busy`.
- `busy` out 1: transmission in progress.
- `numero` out 4: digit driven to the checker. Registered.
- `insere` out 1: one-cycle digit strobe. Registered.
- `fim_jogo` out 1: one-cycle end-of-game strobe. Registered.
- `done` out 1: one-cycle pulse on normal completion.
- `erro` out 1: one-cycle pulse when a bet is rejected.
- `jogos` out 8: count of completed games. Wraps from 255 to 0.

## Operation
- Reset values: `numero`=0, `insere`=0, `fim_jogo`=0, `busy`=0, `done`=0, `erro`=0, `jogos`=0, state IDLE. Reset has priority over every other input.
- States: IDLE, SEND, WAIT, FIM, DONE.
- IDLE + `start` + all digits ≤ 9:
  - latch `aposta` into the shift register;
  - set digit index to 0;
  - go to SEND.
- IDLE + `start` + any digit > 9: pulse `erro` for one cycle, stay in IDLE, no strobes, `jogos` unchanged.
- SEND:
  - drive `numero` = digit[idx] with `insere`=1 for exactly one cycle;
  - if idx = NDIGITS-1, go to FIM after `GAP` idle cycles;
  - otherwise go to SEND for idx+1 after `GAP` idle cycles.
  - With `GAP`=0, strobes are back-to-back; WAIT is skipped.
- WAIT: `insere`=0, `numero` holds the last sent digit, a 4-bit gap counter counts down.
- FIM: `fim_jogo`=1 for one cycle, `numero` = last digit (the checker samples the final digit on `fim_jogo`).
- DONE:
  - `done`=1 for one cycle;
  - `jogos` increments modulo 256;
  - `numero` returns to 0;
  - `busy`=0, so `start` is accepted in this same cycle.
- `cancela` while `busy`:
  - next cycle: IDLE, all strobes 0, `numero`=0;
  - no `done`, no `fim_jogo`;
  - `jogos` unchanged.
- `cancela` in IDLE/DONE has no effect, but it blocks `start` in that cycle (`cancela` wins).
- `start` while `busy` is ignored; the latched bet is not disturbed.
- Changes on `aposta` after acceptance have no effect.
- `insere` and `fim_jogo` are never high in the same cycle.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high while `ready`=1.
- `insere` for digit i is high in cycle 1 + i·(GAP+1), for i = 0..NDIGITS-1.
- `fim_jogo` is high in cycle 1 + NDIGITS·(GAP+1).
- `done` is high, and `jogos` has incremented, in cycle 2 + NDIGITS·(GAP+1).
- `busy` is high from cycle 1 through the `fim_jogo` cycle inclusive.
- `erro` for a rejected bet is high in cycle 1; `busy` stays 0.
- `cancela` sampled high in cycle c gives idle outputs in cycle c+1.
- Asynchronous `reset` mid-transmission clears outputs immediately; no partial strobe is stretched.

## Test plan
- `aposta`=0x53820, GAP=1 → `insere` in cycles 1,3,5,7,9 with `numero` 5,3,8,2,0; `fim_jogo` in cycle 11 with `numero`=0; `done` in cycle 12; `jogos`=1.
- GAP=0, `aposta`=0x12345 → `insere` in cycles 1–5 with `numero` 1..5; `fim_jogo` in cycle 6; `done` in cycle 7. Then `start` in the `done` cycle with 0x00000 → next `insere` in cycle 8.
- `aposta`=0x5A820 → `erro` in cycle 1; no `insere`; `busy`=0; `jogos` unchanged.
- `cancela` in cycle 4 of a GAP=1 send of 0x53820 → cycle 5 all outputs 0, no `fim_jogo` or `done`; a later full send gives `jogos`=1.
- `start` pulsed again during `busy` with a different bet → original digits are sent unchanged; only one `done`.
- 256 back-to-back games → `jogos` wraps to 0. Assert `reset` during the third strobe → outputs 0 immediately, `jogos`=0.

Source files
------------

// File: rtl/aposta_tx.sv
// Bet transmitter: latches NDIGITS BCD digits on start and replays them to the
// checker as timed insere strobes followed by a single fim_jogo strobe.
module aposta_tx #(
  parameter int NDIGITS = 5,
  parameter int GAP     = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   cancela,
  input  logic [4*NDIGITS-1:0]   aposta,
  output logic                   ready,
  output logic                   busy,
  output logic [3:0]             numero,
  output logic                   insere,
  output logic                   fim_jogo,
  output logic                   done,
  output logic                   erro,
  output logic [7:0]             jogos
);

  localparam int W  = 4 * NDIGITS;
  localparam int IW = (NDIGITS > 2) ? $clog2(NDIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);
  localparam logic [3:0]    GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
    S_WAIT = 3'd2,
    S_FIM  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state_q;
  logic [W-1:0]  sr_q;
  logic [IW-1:0] idx_q;
  logic [3:0]    gap_q;
  logic [3:0]    numero_q;
  logic          insere_q;
  logic          fim_q;
  logic          done_q;
  logic          erro_q;
  logic          busy_q;
  logic [7:0]    jogos_q;

  logic          aposta_ok_d;
  logic          advance_d;

  function automatic logic all_bcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // Bet validity and "gap elapsed, move to next strobe" decode
  always_comb begin
    aposta_ok_d = all_bcd(aposta);
    advance_d   = 1'b0;
    if (state_q == S_SEND) begin
      advance_d = (GAP == 0);
    end else if (state_q == S_WAIT) begin
      advance_d = (gap_q == 4'd0);
    end else begin
      advance_d = 1'b0;
    end
  end

  // Transmit FSM; strobes default low so every pulse lasts exactly one cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      idx_q    <= '0;
      gap_q    <= 4'd0;
      numero_q <= 4'd0;
      insere_q <= 1'b0;
      fim_q    <= 1'b0;
      done_q   <= 1'b0;
      erro_q   <= 1'b0;
      busy_q   <= 1'b0;
      jogos_q  <= 8'd0;
    end else begin
      insere_q <= 1'b0;
      fim_q    <= 1'b0;
      done_q   <= 1'b0;
      erro_q   <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q  <= S_IDLE;
          numero_q <= 4'd0;
          if (start && !cancela) begin
            if (aposta_ok_d) begin
              state_q  <= S_SEND;
              numero_q <= aposta[W-1 -: 4];
              sr_q     <= {aposta[W-5:0], 4'd0};
              idx_q    <= '0;
              insere_q <= 1'b1;
              busy_q   <= 1'b1;
            end else begin
              erro_q <= 1'b1;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_SEND, S_WAIT, S_FIM: begin
          if (cancela) begin
            state_q  <= S_IDLE;
            numero_q <= 4'd0;
            busy_q   <= 1'b0;
          end else if (state_q == S_FIM) begin
            state_q  <= S_DONE;
            numero_q <= 4'd0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            jogos_q  <= jogos_q + 8'd1;
          end else if (advance_d) begin
            // numero keeps the last digit through FIM so the checker can sample it
            if (idx_q == LAST_IDX) begin
              state_q <= S_FIM;
              fim_q   <= 1'b1;
            end else begin
              state_q  <= S_SEND;
              numero_q <= sr_q[W-1 -: 4];
              sr_q     <= {sr_q[W-5:0], 4'd0};
              idx_q    <= idx_q + IW'(1);
              insere_q <= 1'b1;
            end
          end else if (state_q == S_SEND) begin
            state_q <= S_WAIT;
            gap_q   <= GAP_LOAD;
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          numero_q <= 4'd0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign ready    = !busy_q;
  assign numero   = numero_q;
  assign insere   = insere_q;
  assign fim_jogo = fim_q;
  assign done     = done_q;
  assign erro     = erro_q;
  assign jogos    = jogos_q;

endmodule
